dm_unit: RTL
============

DM_UNIT -- requirements
Module: dm_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words in the data array; must be a power of two.
REQ-002 SHALL have parameter ADDR_W, default 10: byte-address bits used, log2(DEPTH_WORDS)+2.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port DMWr  input  1  store enable for the current cycle.
REQ-006 SHALL have port DMType  input  3  access width/sign: word, halfword, halfword-unsigned, byte, byte-unsigned.
REQ-007 SHALL have port addr  input  32  byte address, from the ALU result.
REQ-008 SHALL have port din  input  32  store data, from rs2.
REQ-009 SHALL have port dout  output  32  load data, extended; feeds the write-back select MEM leg.
REQ-010 SHALL have port misalign  output  1  combinational: the current access is misaligned or DMType is invalid.
REQ-011 SHALL have port err_sticky  output  1  registered: set by any faulting store or load attempt.
REQ-012 SHALL have port store_cnt  output  16  registered count of stores committed.

Function
REQ-013 Array SHALL be DEPTH_WORDS x 32 bits; word index = addr[ADDR_W-1:2]; bits above ADDR_W-1 ignored (address wraps modulo 4*DEPTH_WORDS).
REQ-014 Loads SHALL be combinational, 0-cycle latency: dout valid in the same cycle as addr/DMType.
REQ-015 Word load SHALL return the full word.
REQ-016 Halfword loads SHALL select the lane from addr[1]; signed loads sign-extend bit 15, unsigned loads zero-extend.
REQ-017 Byte loads SHALL select the lane from addr[1:0]; signed loads sign-extend bit 7, unsigned loads zero-extend.
REQ-018 Stores SHALL commit on the rising clk edge when DMWr=1, writing only the addressed byte lanes.
REQ-019 Word stores SHALL write din[31:0]; halfword stores write din[15:0]; byte stores write din[7:0]; untouched lanes SHALL retain their value.
REQ-020 Misaligned SHALL mean: word with addr[1:0]!=0, or any halfword type with addr[0]=1; byte accesses are never misaligned.
REQ-021 When misalign=1, the store SHALL be suppressed (array unchanged, store_cnt unchanged) and dout SHALL be 0.
REQ-022 An undefined DMType SHALL assert misalign; no store, dout=0.
REQ-023 err_sticky SHALL set on a clock edge where misalign=1 and either DMWr=1 or the access is a load (DMWr=0, DMType valid-width but misaligned); once set, it holds until rst.
REQ-024 store_cnt SHALL increment by 1 per committed store and wrap from 0xFFFF to 0x0000.
REQ-025 Read-during-write to the same address SHALL return the old data in that cycle and the new data from the next cycle.

Reset
REQ-026 rst=1 SHALL asynchronously clear every array word to 0, err_sticky to 0 and store_cnt to 0; dout therefore reads 0.
REQ-027 A store coincident with rst=1 SHALL NOT commit; normal operation resumes on the first rising edge after rst falls.

Structure
REQ-028 DMType encodings SHALL live in the shared ctrl_encode_def.v header: word 3'b000, halfword 3'b001, halfword-unsigned 3'b010, byte 3'b011, byte-unsigned 3'b100.
REQ-029 Load lane extraction and extension SHALL sit in one combinational sub-module, dm_load_ext; the array, store masking and counters stay in dm_unit.

Verification
REQ-030 Reset, then a word store of 0x8765_4321 at addr 0x10 -> a word load at 0x10 returns 0x8765_4321; store_cnt=1.
REQ-031 A byte store of 0xAB at 0x13 over 0x8765_4321 -> word load gives 0xAB65_4321; byte load at 0x13 gives 0xFFFF_FFAB; byte-unsigned gives 0x0000_00AB.
REQ-032 Halfword store of 0x8001 at 0x22 -> halfword load gives 0xFFFF_8001, unsigned gives 0x0000_8001, word load gives 0x8001_0000.
REQ-033 Word store at 0x15 -> misalign=1, array unchanged, store_cnt unchanged, err_sticky=1 after the edge and held until rst.
REQ-034 Store at addr 0x400 with DEPTH_WORDS=256 -> aliases to 0x000; 65536 committed stores -> store_cnt wraps to 0.
REQ-035 Assert rst mid-run after stores -> all reads return 0, store_cnt=0 and err_sticky=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dm_unit_pkg.sv
// dm_unit_pkg: access-type encodings and alignment rule shared by the data-memory unit
package dm_unit_pkg;
  typedef enum logic [2:0] {
    DM_WORD  = 3'b000,
    DM_HALF  = 3'b001,
    DM_HALFU = 3'b010,
    DM_BYTE  = 3'b011,
    DM_BYTEU = 3'b100
  } dm_type_e;
  function automatic logic dm_type_valid(input logic [2:0] t);
    return t <= DM_BYTEU;
  endfunction
  function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] a);
    return !dm_type_valid(t) ||
           (t == DM_WORD && a != 2'b00) ||
           ((t == DM_HALF || t == DM_HALFU) && a[0]);
  endfunction
endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: lane extraction and sign/zero extension of a loaded word
//   i_word  : raw 32-bit word from the array
//   i_type  : access type
//   i_addr  : low byte-address bits selecting the lane
//   i_mis   : forces the result to zero for faulting accesses
//   o_data  : extended load data
module dm_load_ext
  import dm_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_addr,
  input  logic        i_mis,
  output logic [31:0] o_data
);
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
  assign w_byte = i_word[{i_addr, 3'b000} +: 8];
  always_comb begin
    o_data = 32'd0;
    if (!i_mis)
      o_data = i_type == DM_WORD  ? i_word :
               i_type == DM_HALF  ? {{16{w_half[15]}}, w_half} :
               i_type == DM_HALFU ? {16'd0, w_half} :
               i_type == DM_BYTE  ? {{24{w_byte[7]}}, w_byte} :
               i_type == DM_BYTEU ? {24'd0, w_byte} : 32'd0;
  end
endmodule

// File: rtl/dm_unit.sv
// dm_unit: byte-addressable data memory with masked stores, combinational loads and fault tracking
//   clk, rst   : clock, asynchronous active-high reset (clears the whole array)
//   DMWr       : store enable
//   DMType     : access width/sign
//   addr, din  : byte address and store data
//   dout       : extended load data (0 on a faulting access)
//   misalign   : current access is misaligned or DMType is undefined
//   err_sticky : latched fault flag
//   store_cnt  : committed-store counter
module dm_unit
  import dm_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMWr,
  input  logic [2:0]  DMType,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        misalign,
  output logic        err_sticky,
  output logic [15:0] store_cnt
);
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [ADDR_W-3:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_commit;
  logic              w_unused;
  assign w_idx    = addr[ADDR_W-1:2];
  assign w_unused = ^addr[31:ADDR_W];
  assign misalign = dm_misaligned(DMType, addr[1:0]);
  assign w_commit = DMWr && !misalign;
  always_comb begin
    w_be    = DMType == DM_WORD ? 4'b1111 :
              (DMType == DM_HALF || DMType == DM_HALFU) ? (addr[1] ? 4'b1100 : 4'b0011) :
              4'b0001 << addr[1:0];
    w_wdata = DMType == DM_WORD ? din :
              (DMType == DM_HALF || DMType == DM_HALFU) ? {2{din[15:0]}} :
              {4{din[7:0]}};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
    end else if (w_commit) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end
  // Invalid-type loads are not faults; invalid-type stores and any misaligned valid access are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_cnt  <= 16'd0;
      err_sticky <= 1'b0;
    end else begin
      if (w_commit) store_cnt <= store_cnt + 16'd1;
      if (misalign && (DMWr || dm_type_valid(DMType))) err_sticky <= 1'b1;
    end
  end
  dm_load_ext u_ext (
    .i_word (r_mem[w_idx]),
    .i_type (DMType),
    .i_addr (addr[1:0]),
    .i_mis  (misalign),
    .o_data (dout)
  );
endmodule
